// File: rtl/all_pkgs.sv
// Shared RV32 core definitions: opcodes, branch/writeback encodings and the
// bundled decode-control struct carried down the pipeline.
package all_pkgs;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE    = 7'b0010011;
  localparam logic [6:0] I_LOAD    = 7'b0000011;
  localparam logic [6:0] S_TYPE    = 7'b0100011;
  localparam logic [6:0] B_TYPE    = 7'b1100011;
  localparam logic [6:0] J_TYPE    = 7'b1101111;
  localparam logic [6:0] JALR_TYPE = 7'b1100111;

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LTU  = 3'd5;
  localparam logic [2:0] BR_GEU  = 3'd6;
  localparam logic [2:0] BR_JUMP = 3'd7;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  typedef struct packed {
    logic       reg_wr_en;
    logic       alu_src;
    logic       mem_wr_en;
    logic       mem_rd_en;
    logic       mem_to_reg;
    logic [2:0] branch_op;
    logic [1:0] wb_sel;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{reg_wr_en: 1'b0, alu_src: 1'b0, mem_wr_en: 1'b0,
                                 mem_rd_en: 1'b0, mem_to_reg: 1'b0,
                                 branch_op: BR_NONE, wb_sel: WB_ALU};

  function automatic logic op_uses_rs1(input logic [6:0] op);
    case (op)
      R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE, JALR_TYPE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic op_uses_rs2(input logic [6:0] op);
    case (op)
      R_TYPE, S_TYPE, B_TYPE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard check between the load in EX and the
// instruction in ID. Pipeline-control gating (flush/hold) is left to the user.
module load_use_detect
  import all_pkgs::*;
(
  input  logic       id_valid,
  input  logic [6:0] id_opcode,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       ex_valid,
  input  logic       ex_mem_rd_en,
  input  logic [4:0] ex_rd,
  output logic       load_use_stall
);

  logic rs1_hit;
  logic rs2_hit;

  always_comb begin
    rs1_hit = op_uses_rs1(id_opcode) && (id_rs1 == ex_rd);
    rs2_hit = op_uses_rs2(id_opcode) && (id_rs2 == ex_rd);
    load_use_stall = ex_valid && ex_mem_rd_en && id_valid && (ex_rd != '0) &&
                     (rs1_hit || rs2_hit);
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush and hold.
// Optional perf counters are enabled with `define ID_EX_PERF_CNT_EN.
module id_ex_stage
  import all_pkgs::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            id_valid,
  input  logic [6:0]      id_opcode,
  input  logic [2:0]      id_funct3,
  input  logic [6:0]      id_funct7,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  input  logic            id_reg_wr_en,
  input  logic            id_alu_src,
  input  logic            id_mem_wr_en,
  input  logic            id_mem_rd_en,
  input  logic            id_mem_to_reg,
  input  logic [2:0]      id_branch_op,
  input  logic [1:0]      id_wb_sel,
  input  logic            flush,
  input  logic            hold,
  output logic            load_use_stall,
  output logic            ex_valid,
  output logic [6:0]      ex_opcode,
  output logic [2:0]      ex_funct3,
  output logic [6:0]      ex_funct7,
  output logic [4:0]      ex_rs1,
  output logic [4:0]      ex_rs2,
  output logic [4:0]      ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic            ex_reg_wr_en,
  output logic            ex_alu_src,
  output logic            ex_mem_wr_en,
  output logic            ex_mem_rd_en,
  output logic            ex_mem_to_reg,
  output logic [2:0]      ex_branch_op,
  output logic [1:0]      ex_wb_sel
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] perf_bubble_cnt,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_hold_cnt
`endif
);

  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;
  logic  load_data;

  assign id_ctrl = '{reg_wr_en: id_reg_wr_en, alu_src: id_alu_src, mem_wr_en: id_mem_wr_en,
                     mem_rd_en: id_mem_rd_en, mem_to_reg: id_mem_to_reg,
                     branch_op: id_branch_op, wb_sel: id_wb_sel};

  load_use_detect u_load_use_detect (
    .id_valid      (id_valid),
    .id_opcode     (id_opcode),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_valid      (ex_valid),
    .ex_mem_rd_en  (ex_ctrl.mem_rd_en),
    .ex_rd         (ex_rd),
    .load_use_stall(hazard)
  );

  assign load_use_stall = hazard && !flush && !hold;
  // Data fields follow ID in every case except a plain hold.
  assign load_data      = flush || !hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (flush || (!hold && load_use_stall)) begin
      ex_valid <= 1'b0;
      ex_ctrl  <= CTRL_NOP;
    end else if (!hold) begin
      ex_valid <= id_valid;
      ex_ctrl  <= id_valid ? id_ctrl : CTRL_NOP;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_opcode   <= '0;
      ex_funct3   <= '0;
      ex_funct7   <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else if (load_data) begin
      ex_opcode   <= id_opcode;
      ex_funct3   <= id_funct3;
      ex_funct7   <= id_funct7;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_pc       <= id_pc;
    end
  end

  assign ex_reg_wr_en  = ex_ctrl.reg_wr_en;
  assign ex_alu_src    = ex_ctrl.alu_src;
  assign ex_mem_wr_en  = ex_ctrl.mem_wr_en;
  assign ex_mem_rd_en  = ex_ctrl.mem_rd_en;
  assign ex_mem_to_reg = ex_ctrl.mem_to_reg;
  assign ex_branch_op  = ex_ctrl.branch_op;
  assign ex_wb_sel     = ex_ctrl.wb_sel;

`ifdef ID_EX_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_bubble_cnt <= '0;
      perf_flush_cnt  <= '0;
      perf_hold_cnt   <= '0;
    end else begin
      if (load_use_stall && perf_bubble_cnt != '1)
        perf_bubble_cnt <= perf_bubble_cnt + CNT_W'(1);
      if (flush && (ex_valid || id_valid) && perf_flush_cnt != '1)
        perf_flush_cnt <= perf_flush_cnt + CNT_W'(1);
      if (hold && !flush && perf_hold_cnt != '1)
        perf_hold_cnt <= perf_hold_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register for the pipelined RV32 core. It captures decoded operands and the control_unit outputs at the end of decode and presents them to execute.
- Contains load-use hazard detection. It stalls IF/ID and inserts a bubble when the instruction in EX is a load whose rd is read by the instruction in ID.
- Handles branch/jump flush from EX and an external hold from the memory side.

Parameters:
XLEN, 32, datapath width
CNT_W, 32, perf-counter width (used only with the optional feature)

Ports:
clk  in  1  core clock
rst_n  in  1  reset; asynchronous, active-low
id_valid  in  1  ID holds a real instruction
id_opcode  in  7  instruction opcode (all_pkgs opcode constants)
id_funct3  in  3  funct3
id_funct7  in  7  funct7
id_rs1, id_rs2, id_rd  in  5 each  register indices
id_rs1_data, id_rs2_data  in  XLEN each  register-file read data
id_imm  in  XLEN  sign-extended immediate
id_pc  in  XLEN  instruction PC
id_reg_wr_en, id_alu_src, id_mem_wr_en, id_mem_rd_en, id_mem_to_reg  in  1 each  decoded control
id_branch_op  in  3  branch type (BR_* constants)
id_wb_sel  in  2  writeback select: 00 ALU, 01 MEM, 10 PC+4
flush  in  1  branch/jump taken in EX; kill the ID instruction
hold  in  1  downstream stall; freeze the stage
load_use_stall  out  1  to IF/ID and PC: hold fetch/decode this cycle
ex_valid  out  1  EX holds a real instruction
ex_opcode, ex_funct3, ex_funct7, ex_rs1, ex_rs2, ex_rd, ex_rs1_data, ex_rs2_data, ex_imm, ex_pc  out  same widths as id_*  registered copies
ex_reg_wr_en, ex_alu_src, ex_mem_wr_en, ex_mem_rd_en, ex_mem_to_reg, ex_branch_op, ex_wb_sel  out  same widths  registered control

Behaviour:
- Reset (rst_n low, asynchronous): every ex_* output is 0; ex_branch_op = BR_NONE; ex_valid = 0.
- load_use_stall is combinational. It is 1 when all of the following hold:
  - ex_valid, ex_mem_rd_en and id_valid are all 1
  - ex_rd != 0
  - (uses_rs1 and id_rs1 == ex_rd) or (uses_rs2 and id_rs2 == ex_rd)
- uses_rs1 = 1 for opcode R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE, JALR_TYPE; 0 for J_TYPE and unknown opcodes.
- uses_rs2 = 1 for R_TYPE, S_TYPE, B_TYPE only.
- load_use_stall is forced to 0 while flush = 1 or hold = 1.
- Update on each rising clk edge, first matching rule wins:
  1. flush = 1: ex_valid <= 0, all control <= 0 / BR_NONE. Flush beats hold.
  2. hold = 1: every ex_* register keeps its value.
  3. load_use_stall = 1: bubble. ex_valid <= 0, control cleared. The ID instruction is not consumed (upstream holds it); it is captured one cycle later.
  4. Otherwise: all ex_* <= id_*, and ex_valid <= id_valid.
     - If id_valid = 0, control fields are loaded as 0 / BR_NONE regardless of id_* control values.
- Invariant: ex_valid = 0 implies ex_reg_wr_en = ex_mem_wr_en = ex_mem_rd_en = 0 and ex_branch_op = BR_NONE.
- Data fields (rs*_data, imm, pc, indices, funct) are loaded in rules 1, 3 and 4 and retained in rule 2.
- Latency: one cycle from ID to EX. A load-use pair costs exactly one bubble.
- Back-to-back loads: the second load may itself trigger a stall against the first. Each stall is evaluated independently every cycle.
- rd = x0 never causes a stall.
- Asserting rst_n low mid-stall clears the stage immediately; load_use_stall drops to 0 because ex_valid = 0.

Optional Feature:
- Macro: ID_EX_PERF_CNT_EN.
- When defined, three extra outputs, CNT_W bits each, cleared at reset, saturating at all-ones:
  - perf_bubble_cnt: +1 on each rule-3 cycle
  - perf_flush_cnt: +1 on each cycle with flush = 1 while ex_valid or id_valid is 1
  - perf_hold_cnt: +1 on each rule-2 cycle
- When undefined: ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- all_pkgs gets:
  - opcode constants (R_TYPE, I_TYPE, I_LOAD, S_TYPE, B_TYPE, J_TYPE, JALR_TYPE) and BR_* encodings (existing)
  - new WB_ALU = 2'b00, WB_MEM = 2'b01, WB_PC4 = 2'b10
  - a packed struct ctrl_t bundling the seven control fields, with a CTRL_NOP constant (all 0, BR_NONE)
- One sub-module: load_use_detect, a purely combinational producer of load_use_stall. Instantiated here; reusable by a later forwarding unit.

Test Plan:
- Reset: rst_n = 0 with random id_* inputs -> all ex_* = 0, ex_valid = 0, load_use_stall = 0. Release, then present one R_TYPE (rd = 5, pc = 0x100) -> next cycle ex_valid = 1, ex_rd = 5, ex_pc = 0x100, ex_reg_wr_en = 1.
- Load-use:
  - EX holds lw x3 and ID holds add x4, x3, x1 -> load_use_stall = 1 for one cycle. EX gets a bubble (ex_valid = 0, ex_reg_wr_en = 0), and the add enters EX on the following cycle.
  - Same pair with ID add x4, x1, x2 -> no stall.
- x0 and rs2 usage:
  - lw x0 followed by add x1, x0, x0 -> no stall.
  - lw x7 followed by addi x2, x5, 7 with id_rs2 field = 7 -> no stall (I_TYPE does not use rs2).
  - lw x7 followed by sw x7, 0(x5) -> stall.
- Flush priority: flush = 1 together with hold = 1 and a valid ID beq (BR_EQ) -> next cycle ex_valid = 0, ex_branch_op = BR_NONE. With flush = 1 and a load-use condition present -> load_use_stall = 0.
- Hold: hold = 1 for 3 cycles while ID changes every cycle -> ex_* unchanged for all 3 cycles. After release, the current ID instruction is captured.
- Perf (ID_EX_PERF_CNT_EN): 2 load-use events, 1 flush and 4 hold cycles -> counters 2/1/4. Preload a counter at all-ones and trigger another event -> it stays at all-ones.
